// File: rtl/gpu_pixel_burst_writer.sv
// gpu_pixel_burst_writer
// Coalesces 32-bit pixel pairs that share a 16-pixel VRAM line segment into
// one 256-bit masked burst. One accumulate slot (ACC) plus one issue slot
// (ISSUE) let the pixel pipe keep running while a burst waits for the arbiter.
// Optional build macro: GPU_BURST_STATS_EN adds burst/stall statistic outputs.
module gpu_pixel_burst_writer #(
   parameter int unsigned IDLE_TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         i_nrst,
   input  logic         i_pxValid,
   output logic         o_pxReady,
   input  logic [8:0]   i_pxY,
   input  logic [8:0]   i_pxPairX,
   input  logic [31:0]  i_write32,
   input  logic         i_selL,
   input  logic         i_selR,
   input  logic         i_flush,
   output logic         o_flushDone,
   output logic         o_memReq,
   input  logic         i_memAck,
   output logic [14:0]  o_memAddr,
   output logic [255:0] o_memData,
   output logic [15:0]  o_memMask
`ifdef GPU_BURST_STATS_EN
   ,
   output logic [15:0]  o_statBursts,
   output logic [15:0]  o_statStalls
`endif
);

   localparam int unsigned CntW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] IdleMax = CntW'(IDLE_TIMEOUT);

   // accumulate slot; data/mask are kept at zero whenever the slot is empty
   logic          accValid;
   logic [14:0]   accTag;
   logic [255:0]  accData;
   logic [15:0]   accMask;
   logic          issValid;
   logic [CntW-1:0] idleCnt;
   logic          flushPending;

   logic [14:0]   inTag;
   logic [2:0]    lane;
   logic          tagHit;
   logic          issFree;
   logic          accept;
   logic          idleHit;
   logic          moveAcc;
   logic          accValidNext;
   logic [14:0]   accTagNext;
   logic [255:0]  accDataNext;
   logic [15:0]   accMaskNext;
   logic          issValidNext;
   logic [CntW-1:0] idleNext;
   logic          flushAct;

   // handshake, slot-move decision and next ACC contents
   always_comb begin
      inTag    = {i_pxY, i_pxPairX[8:3]};
      lane     = i_pxPairX[2:0];
      tagHit   = accValid && (accTag == inTag);
      issFree  = !issValid || i_memAck;
      o_memReq = issValid;
      o_pxReady = i_nrst && !flushPending && (!accValid || tagHit || issFree);
      accept   = i_pxValid && o_pxReady;
      idleHit  = (IDLE_TIMEOUT != 0) && accValid && (idleCnt == IdleMax);
      moveAcc  = accValid && issFree &&
                 ((&accMask) || idleHit || flushPending || (accept && !tagHit));

      // a move empties ACC first, so a pair accepted on that edge starts fresh
      accValidNext = accValid && !moveAcc;
      accTagNext   = accTag;
      accDataNext  = moveAcc ? '0 : accData;
      accMaskNext  = moveAcc ? '0 : accMask;
      if (accept) begin
         accValidNext = 1'b1;
         accTagNext   = inTag;
         if (i_selL) begin
            accDataNext[{lane, 5'd0} +: 16] = i_write32[15:0];
            accMaskNext[{lane, 1'b0}]       = 1'b1;
         end
         if (i_selR) begin
            accDataNext[{lane, 5'd16} +: 16] = i_write32[31:16];
            accMaskNext[{lane, 1'b1}]        = 1'b1;
         end
      end

      issValidNext = moveAcc || (issValid && !i_memAck);

      idleNext = idleCnt;
      if (accept || !accValid || moveAcc) begin
         idleNext = '0;
      end else if (idleCnt != IdleMax) begin
         idleNext = idleCnt + CntW'(1);
      end

      flushAct = flushPending || i_flush;
   end

   // slot registers, idle counter and flush tracking
   always_ff @(posedge clk) begin
      if (!i_nrst) begin
         accValid     <= 1'b0;
         accTag       <= '0;
         accData      <= '0;
         accMask      <= '0;
         issValid     <= 1'b0;
         o_memAddr    <= '0;
         o_memData    <= '0;
         o_memMask    <= '0;
         idleCnt      <= '0;
         flushPending <= 1'b0;
         o_flushDone  <= 1'b0;
      end else begin
         accValid <= accValidNext;
         accTag   <= accTagNext;
         accData  <= accDataNext;
         accMask  <= accMaskNext;
         issValid <= issValidNext;
         if (moveAcc) begin
            o_memAddr <= accTag;
            o_memData <= accData;
            o_memMask <= accMask;
         end
         idleCnt <= idleNext;
         // done is judged on next-state emptiness so it lands one cycle after the last ack
         if (flushAct && !accValidNext && !issValidNext) begin
            o_flushDone  <= 1'b1;
            flushPending <= 1'b0;
         end else begin
            o_flushDone  <= 1'b0;
            flushPending <= flushAct;
         end
      end
   end

`ifdef GPU_BURST_STATS_EN
   // acked-burst counter (wraps) and stall-cycle counter (saturates)
   always_ff @(posedge clk) begin
      if (!i_nrst) begin
         o_statBursts <= '0;
         o_statStalls <= '0;
      end else begin
         if (issValid && i_memAck) begin
            o_statBursts <= o_statBursts + 16'd1;
         end
         if (i_pxValid && !o_pxReady && (o_statStalls != 16'hFFFF)) begin
            o_statStalls <= o_statStalls + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_gpu_pixel_burst_writer.sv
// Directed, table-driven bench for gpu_pixel_burst_writer.
module tb_gpu_pixel_burst_writer;

   localparam int unsigned TO = 16;

   logic         clk = 1'b0;
   logic         i_nrst;
   logic         i_pxValid;
   logic         o_pxReady;
   logic [8:0]   i_pxY;
   logic [8:0]   i_pxPairX;
   logic [31:0]  i_write32;
   logic         i_selL;
   logic         i_selR;
   logic         i_flush;
   logic         o_flushDone;
   logic         o_memReq;
   logic         i_memAck;
   logic [14:0]  o_memAddr;
   logic [255:0] o_memData;
   logic [15:0]  o_memMask;
`ifdef GPU_BURST_STATS_EN
   logic [15:0]  o_statBursts;
   logic [15:0]  o_statStalls;
`endif

   gpu_pixel_burst_writer #(.IDLE_TIMEOUT(TO)) dut (
      .clk(clk), .i_nrst(i_nrst), .i_pxValid(i_pxValid), .o_pxReady(o_pxReady),
      .i_pxY(i_pxY), .i_pxPairX(i_pxPairX), .i_write32(i_write32),
      .i_selL(i_selL), .i_selR(i_selR), .i_flush(i_flush), .o_flushDone(o_flushDone),
      .o_memReq(o_memReq), .i_memAck(i_memAck), .o_memAddr(o_memAddr),
      .o_memData(o_memData), .o_memMask(o_memMask)
`ifdef GPU_BURST_STATS_EN
      , .o_statBursts(o_statBursts), .o_statStalls(o_statStalls)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         vld;
      logic [8:0]   y;
      logic [8:0]   px;
      logic [31:0]  w;
      logic         sl, sr, fl, ack;
      logic         eRdy, eReq, eDone;
      logic [14:0]  eAddr;
      logic [15:0]  eMask;
      logic         chkD;
      logic [255:0] eData;
   } vec_t;

   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic vld, input logic [8:0] y, input logic [8:0] px,
                               input logic [31:0] w, input logic sl, input logic sr,
                               input logic fl, input logic ack, input logic eRdy,
                               input logic eReq, input logic eDone,
                               input logic [14:0] eAddr, input logic [15:0] eMask);
      vec_t v;
      v.vld = vld; v.y = y; v.px = px; v.w = w; v.sl = sl; v.sr = sr; v.fl = fl;
      v.ack = ack; v.eRdy = eRdy; v.eReq = eReq; v.eDone = eDone;
      v.eAddr = eAddr; v.eMask = eMask; v.chkD = 1'b0; v.eData = '0;
      return v;
   endfunction

   function automatic logic [255:0] expand(input logic [15:0] m);
      logic [255:0] r = '0;
      for (int k = 0; k < 16; k++) if (m[k]) r[16*k +: 16] = 16'hFFFF;
      return r;
   endfunction

   function automatic logic [255:0] px2(input int k0, input logic [15:0] a,
                                        input int k1, input logic [15:0] b);
      logic [255:0] r = '0;
      r[16*k0 +: 16] = a;
      r[16*k1 +: 16] = b;
      return r;
   endfunction

   // one cycle: drive after the edge, check mid-cycle, advance
   task automatic apply(input vec_t v, input int idx);
      i_pxValid = v.vld; i_pxY = v.y; i_pxPairX = v.px; i_write32 = v.w;
      i_selL = v.sl; i_selR = v.sr; i_flush = v.fl; i_memAck = v.ack;
      @(negedge clk);
      chk($sformatf("v%0d ready", idx), 256'(o_pxReady), 256'(v.eRdy));
      chk($sformatf("v%0d memReq", idx), 256'(o_memReq), 256'(v.eReq));
      chk($sformatf("v%0d flushDone", idx), 256'(o_flushDone), 256'(v.eDone));
      if (v.eReq) begin
         chk($sformatf("v%0d addr", idx), 256'(o_memAddr), 256'(v.eAddr));
         chk($sformatf("v%0d mask", idx), 256'(o_memMask), 256'(v.eMask));
      end
      if (v.chkD) chk($sformatf("v%0d data", idx), o_memData & expand(v.eMask), v.eData);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      logic [255:0] d;
      int edges;
      int stale;

      // ---- vector table ----
      // full segment y=5, pairX 8..15, ack held high
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(1, 9'd5, 9'(8 + i), {16'(16'h1011 + 2*i), 16'(16'h1010 + 2*i)},
                          1, 1, 0, 1, 1, 0, 0, 15'h0, 16'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 15'h0, 16'h0));
      v = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 15'h141, 16'hFFFF);
      for (int k = 0; k < 16; k++) d[16*k +: 16] = 16'(16'h1010 + k);
      v.chkD = 1; v.eData = d; tbl.push_back(v);
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 15'h0, 16'h0));
      // partial writes to one pair then flush
      tbl.push_back(mk(1, 9'd2, 9'd3, 32'hAAAA_1111, 1, 0, 0, 0, 1, 0, 0, 15'h0, 16'h0));
      tbl.push_back(mk(1, 9'd2, 9'd3, 32'h2222_BBBB, 0, 1, 0, 0, 1, 0, 0, 15'h0, 16'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 15'h0, 16'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0, 16'h0));
      v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 15'h080, 16'h00C0);
      v.chkD = 1; v.eData = px2(6, 16'h1111, 7, 16'h2222); tbl.push_back(v);
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 15'h0, 16'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 15'h0, 16'h0));
      // alternating lines with ack low: stall, stable burst, one slot freed per ack
      tbl.push_back(mk(1, 9'd0, 9'd0, 32'hB0B0_A0A0, 1, 1, 0, 0, 1, 0, 0, 15'h0, 16'h0));
      tbl.push_back(mk(1, 9'd1, 9'd0, 32'hD1D1_C1C1, 1, 1, 0, 0, 1, 0, 0, 15'h0, 16'h0));
      for (int i = 0; i < 3; i++) begin
         v = mk(1, 9'd0, 9'd0, 32'hB0B0_A0A0, 1, 1, 0, (i == 2), (i == 2), 1, 0, 15'h000, 16'h0003);
         v.chkD = 1; v.eData = px2(0, 16'hA0A0, 1, 16'hB0B0); tbl.push_back(v);
      end
      v = mk(1, 9'd1, 9'd0, 32'hD1D1_C1C1, 1, 1, 0, 0, 0, 1, 0, 15'h040, 16'h0003);
      v.chkD = 1; v.eData = px2(0, 16'hC1C1, 1, 16'hD1D1); tbl.push_back(v);
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 15'h040, 16'h0003));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 15'h0, 16'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0, 16'h0));
      v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 15'h000, 16'h0003);
      v.chkD = 1; v.eData = px2(0, 16'hA0A0, 1, 16'hB0B0); tbl.push_back(v);
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 15'h0, 16'h0));

      // ---- reset ----
      i_nrst = 0; i_pxValid = 0; i_pxY = '0; i_pxPairX = '0; i_write32 = '0;
      i_selL = 0; i_selR = 0; i_flush = 0; i_memAck = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset ready", 256'(o_pxReady), 256'(0));
      chk("reset memReq", 256'(o_memReq), 256'(0));
      chk("reset flushDone", 256'(o_flushDone), 256'(0));
      chk("reset addr", 256'(o_memAddr), 256'(0));
      chk("reset data", o_memData, 256'(0));
      chk("reset mask", 256'(o_memMask), 256'(0));
      i_nrst = 1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // ---- idle timeout on a lone pair ----
      i_pxValid = 1; i_pxY = 9'd7; i_pxPairX = 9'd0; i_write32 = 32'h7777_6666;
      i_selL = 1; i_selR = 1;
      @(negedge clk);
      chk("timeout accept ready", 256'(o_pxReady), 256'(1));
      @(posedge clk); #1;
      i_pxValid = 0;
      edges = 0;
      while (edges < 100) begin
         @(posedge clk); edges++; #1;
         if (o_memReq) break;
      end
      chk("timeout latency", 256'(edges), 256'(TO + 1));
      @(negedge clk);
      chk("timeout mask", 256'(o_memMask), 256'(16'h0003));
      chk("timeout addr", 256'(o_memAddr), 256'(15'h1C0));
      chk("timeout data", o_memData & expand(16'h0003), px2(0, 16'h6666, 1, 16'h7777));
      i_memAck = 1;
      @(posedge clk); #1;
      i_memAck = 0;
      @(negedge clk);
      chk("timeout released", 256'(o_memReq), 256'(0));
      @(posedge clk); #1;

      // ---- reset while a burst is outstanding ----
      apply(mk(1, 9'd3, 9'd0, 32'h3333_3333, 1, 1, 0, 0, 1, 0, 0, 15'h0, 16'h0), 100);
      apply(mk(1, 9'd4, 9'd0, 32'h4444_4444, 1, 1, 0, 0, 1, 0, 0, 15'h0, 16'h0), 101);
      i_pxValid = 0;
      i_nrst = 0;
      @(negedge clk);
      chk("pre-reset memReq", 256'(o_memReq), 256'(1));
      @(posedge clk); #1;
      chk("mid reset memReq", 256'(o_memReq), 256'(0));
      chk("mid reset ready", 256'(o_pxReady), 256'(0));
      i_nrst = 1;
      @(negedge clk);
      chk("post reset ready", 256'(o_pxReady), 256'(1));
      stale = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (o_memReq) stale++;
      end
      chk("no stale burst", 256'(stale), 256'(0));

      // ---- three acked bursts with two stall cycles ----
      apply(mk(1, 9'd10, 9'd0, 32'h0A0A_0A0A, 1, 1, 0, 0, 1, 0, 0, 15'h0, 16'h0), 200);
      apply(mk(1, 9'd11, 9'd0, 32'h0B0B_0B0B, 1, 1, 0, 0, 1, 0, 0, 15'h0, 16'h0), 201);
      apply(mk(1, 9'd12, 9'd0, 32'h0C0C_0C0C, 1, 1, 0, 0, 0, 1, 0, 15'h280, 16'h0003), 202);
      apply(mk(1, 9'd12, 9'd0, 32'h0C0C_0C0C, 1, 1, 0, 0, 0, 1, 0, 15'h280, 16'h0003), 203);
      apply(mk(1, 9'd12, 9'd0, 32'h0C0C_0C0C, 1, 1, 0, 1, 1, 1, 0, 15'h280, 16'h0003), 204);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 15'h2C0, 16'h0003), 205);
      apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 15'h0, 16'h0), 206);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0, 16'h0), 207);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 15'h300, 16'h0003), 208);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 15'h0, 16'h0), 209);
`ifdef GPU_BURST_STATS_EN
      chk("stat bursts", 256'(o_statBursts), 256'(3));
      chk("stat stalls", 256'(o_statStalls), 256'(2));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
